// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Widest supported data field; narrower frames are zero-extended.
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

  typedef struct packed {
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Valid/ready port carrying received frames out of the UART receiver.
interface uart_rx_buffered_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data, rx_parity_err, rx_frame_err, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_parity_err, rx_frame_err, rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous frame FIFO; a pop frees a slot for a push in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  uart_rx_entry_t               din,
  output uart_rx_entry_t               head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         drop
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  uart_rx_entry_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  // Storage array; contents are only visible through head when non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Parametrised UART receiver with synchroniser, false-start rejection,
// parity/framing checks and a buffered valid/ready output.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx,
  uart_rx_buffered_if.master                rx_if,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              busy,
  output logic                              ovf,
  input  logic                              ovf_clr
);
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  logic                 rx_meta, rx_s;
  rx_state_t            state, state_n;
  logic [CW-1:0]        clk_cnt, cnt_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  logic                 push;
  uart_rx_entry_t       push_entry, head;
  logic                 empty, drop;
  logic                 at_centre;

  assign at_centre = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign busy      = (state != S_IDLE);

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_n;
      clk_cnt <= cnt_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
    end
  end

  // Frame sequencing: half-bit start check, then centre sampling of each bit.
  always_comb begin
    state_n    = state;
    cnt_n      = clk_cnt;
    bit_n      = bit_cnt;
    shift_n    = shift;
    perr_n     = perr;
    ferr_n     = ferr;
    push       = 1'b0;
    push_entry = '0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (!rx_s) begin
          state_n = S_START;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      S_START: begin
        if (clk_cnt == CW'(HALF - 1)) begin
          cnt_n   = '0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_n = clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (at_centre) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[DATA_BITS-1:1]};
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_n   = '0;
            state_n = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          cnt_n = clk_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (at_centre) begin
          cnt_n   = '0;
          perr_n  = (PARITY == PAR_ODD) ? ~(^{shift, rx_s}) : (^{shift, rx_s});
          state_n = S_STOP;
        end else begin
          cnt_n = clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (at_centre) begin
          cnt_n  = '0;
          ferr_n = ferr | ~rx_s;
          if (bit_cnt == 4'(STOP_BITS - 1)) begin
            bit_n                 = '0;
            push                  = 1'b1;
            push_entry.frame_err  = ferr | ~rx_s;
            push_entry.parity_err = perr;
            push_entry.data       = MAX_DATA_BITS'(shift);
            state_n               = rx_s ? S_IDLE : S_BREAK;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          cnt_n = clk_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rx_if.rx_ready && !empty),
    .din   (push_entry),
    .head  (head),
    .empty (empty),
    .level (level),
    .drop  (drop)
  );

  assign rx_if.rx_valid      = !empty;
  assign rx_if.rx_data       = head.data[DATA_BITS-1:0];
  assign rx_if.rx_parity_err = head.parity_err;
  assign rx_if.rx_frame_err  = head.frame_err;

  // Upper payload bits are zero-extended on push and never carry data.
  if (DATA_BITS < MAX_DATA_BITS) begin : g_pad_check
    always_comb assert (head.data[MAX_DATA_BITS-1:DATA_BITS] == '0);
  end

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
Parametrised UART receiver, successor to the fixed 8N1 bench receiver. Adds configurable data width, parity mode, stop-bit count, input synchronisation, false-start rejection and error flags. Received frames go into an internal FIFO drained through a valid/ready port. It sits between a GPIO pad (for example mprj_io[1]) and any consumer, either bench checker or on-chip logic.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit; must be >= 8
DATA_BITS, 8, data bits per frame, range 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, received-frame buffer entries; power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx  in  1  serial line, idle high, asynchronous to clk
rx_data  out  DATA_BITS  head-of-FIFO data
rx_parity_err  out  1  head-of-FIFO parity error flag
rx_frame_err  out  1  head-of-FIFO framing error flag
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer accepts head entry when rx_valid && rx_ready
level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
busy  out  1  FSM not in IDLE
ovf  out  1  sticky overflow flag
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (async assert, sync release): FSM IDLE, counters 0, FIFO empty, rx_valid=0, level=0, busy=0, ovf=0, rx_data/flags=0, synchroniser flops=1.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s. This adds 2 cycles of latency.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on rx_s==0, go to START with bit counter clk_cnt=0.
- START: count to CLKS_PER_BIT/2-1 (integer division). Then sample: rx_s==0 goes to DATA with clk_cnt=0; rx_s==1 is a false start and returns to IDLE with no push.
- DATA: sample at clk_cnt==CLKS_PER_BIT-1 (bit centre), then reset clk_cnt. Shift into the shift register LSB first. After DATA_BITS samples, go to PARITY if PARITY!=0, else STOP.
- PARITY: one centre sample. Error when the XOR of data bits and the parity bit is 0 for odd, or 1 for even. Flag is always 0 when PARITY==0.
- STOP: STOP_BITS centre samples. Any sample 0 sets frame_err. After the final stop sample, push {frame_err, parity_err, data} in the same cycle.
  - If the final stop sample was 1, go to IDLE; the next start edge can then be detected half a bit later.
  - If it was 0, go to BREAK.
- BREAK: wait until rx_s==1, then IDLE. No further pushes occur during a break.
- Push to a full FIFO: frame dropped, ovf set.
  - Push and pop in the same cycle while full: pop frees the slot and the push is accepted, so ovf is not set.
  - ovf_clr in the same cycle as a new overflow: ovf stays 1 (set wins).
- Pop occurs when rx_valid && rx_ready. rx_data and flags are combinational from the head entry. level updates the cycle after push/pop, and a simultaneous push and pop leaves level unchanged.
- Latency: from the rx falling edge to rx_valid high is ((1+DATA_BITS+(PARITY!=0)+STOP_BITS)-0.5)*CLKS_PER_BIT + 4 cycles, ±1.
- Counter widths: clk_cnt is $clog2(CLKS_PER_BIT) bits. Bit counter is 4 bits. No wrap-around occurs, since counters reset on every terminal count.
- Reset mid-frame: the frame is discarded and all state returns to reset values immediately.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - the FSM state enum;
  - a uart_rx_entry_t struct {frame_err, parity_err, data}.
- The uarttx bench model reuses the parity constants.
- One sub-module: uart_rx_fifo, a synchronous FIFO with push/pop, full/empty and level, same clk/rst scheme.
- The FSM and synchroniser stay in the top module.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send "hi!" (0x68, 0x69, 0x21) back-to-back, rx_ready=1 -> three pops with data 0x68, 0x69, 0x21 in order; both error flags 0; ovf=0.
- PARITY=2 (even), send 0x21 with parity bit 0, then 0x21 with parity bit 1 -> first entry parity_err=0, second parity_err=1, data 0x21 in both.
- Glitch: rx low for 6 cycles (< CLKS_PER_BIT/2) then high -> no push, busy returns to 0, level stays 0.
- Stop bit held low for 3*CLKS_PER_BIT, then high, then send 0x55 -> entry 1 has frame_err=1; exactly one more entry, 0x55 with frame_err=0; no extra entries from the break.
- FIFO_DEPTH=4, rx_ready=0, send 5 frames 0x01..0x05 -> level=4, ovf=1, 0x05 dropped. Then ovf_clr pulse -> ovf=0. Then drain -> 0x01..0x04.
- Assert rst mid-DATA of frame 0x3C, release, send 0xA5 -> only 0xA5 received, no errors.
